// File: rtl/ipd_pkg.sv
// Shared definitions for the multi-channel I-PD servo sequencer.
//   - default widths and channel count
//   - sequencer state encoding
//   - sat_signed(): clamp a signed value to the range of a narrower signed width
package ipd_pkg;

  localparam int unsigned WDef    = 20;
  localparam int unsigned FracDef = 12;
  localparam int unsigned NchDef  = 4;

  // Working width of the saturation helper; callers sign-extend into it.
  localparam int unsigned SatMaxW = 64;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMulI,
    StMulP,
    StMulD,
    StSat
  } state_e;

  // Clamp v to [-2^(bits-1), 2^(bits-1)-1].
  function automatic logic signed [SatMaxW-1:0] sat_signed(
    input logic signed [SatMaxW-1:0] v,
    input int unsigned               bits
  );
    logic signed [SatMaxW-1:0] one;
    logic signed [SatMaxW-1:0] hi;
    logic signed [SatMaxW-1:0] lo;
    one = 1;
    hi  = (one <<< (bits - 1)) - one;
    lo  = -hi - one;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/ipd_mac.sv
// Shared signed multiply-accumulate for the I-PD sequencer (combinational).
//   acc   in  ACCW  running accumulator
//   gain  in  W     signed gain
//   opnd  in  W+2   signed error / difference term
//   sub   in  1     1: res = acc - gain*opnd, 0: res = acc + gain*opnd
//   res   out ACCW  result
module ipd_mac #(
  parameter int unsigned W    = 20,
  parameter int unsigned ACCW = 2 * W + 3
) (
  input  logic signed [ACCW-1:0] acc,
  input  logic signed [W-1:0]    gain,
  input  logic signed [W+1:0]    opnd,
  input  logic                   sub,
  output logic signed [ACCW-1:0] res
);

  localparam int unsigned PW = 2 * W + 2;

  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] prod_x;

  assign prod   = PW'(gain) * PW'(opnd);
  assign prod_x = ACCW'(prod);
  assign res    = sub ? (acc - prod_x) : (acc + prod_x);

endmodule

// File: rtl/ipd_mc_seq.sv
// Time-multiplexed multi-channel I-PD controller (velocity form, one shared MAC).
// Each accepted request updates u[ch] += ki*e - kp*dy - kd*d2y, clamps the stored
// accumulator and publishes the integer part of u.
//   clk      in  1      clock, rising edge
//   rst      in  1      asynchronous active-low reset
//   start    in  1      request pulse, taken only while busy=0
//   ch       in  CHW    requested channel
//   skip_en  in  1      skip the update when y equals the channel's previous y
//   r, y     in  W      setpoint / measurement (signed)
//   ki,kp,kd in  W      gains Q(W-FRAC).FRAC, sampled at accept
//   busy     out 1      computation in progress
//   done     out 1      one-cycle result strobe
//   ch_out   out CHW    channel of the presented result
//   u_out    out W-FRAC saturated, truncated control word
//   err      out 1      one-cycle pulse after a request with ch>=NCH
module ipd_mc_seq
  import ipd_pkg::*;
#(
  parameter int unsigned W    = WDef,
  parameter int unsigned FRAC = FracDef,
  parameter int unsigned NCH  = NchDef,
  localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned ACCW = 2 * W + 3,
  localparam int unsigned UW   = W - FRAC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHW-1:0]       ch,
  input  logic                 skip_en,
  input  logic signed [W-1:0]  r,
  input  logic signed [W-1:0]  y,
  input  logic signed [W-1:0]  ki,
  input  logic signed [W-1:0]  kp,
  input  logic signed [W-1:0]  kd,
  output logic                 busy,
  output logic                 done,
  output logic [CHW-1:0]       ch_out,
  output logic signed [UW-1:0] u_out,
  output logic                 err
);

  localparam int unsigned EW = W + 2;

  state_e state_q, state_d;

  logic [CHW-1:0]        ch_q, ch_out_q;
  logic signed [W-1:0]   r_q, y_q, ki_q, kp_q, kd_q;
  logic                  skip_en_q, skip_q;
  logic signed [EW-1:0]  e_q, dy_q, d2y_q;
  logic signed [ACCW-1:0] acc_q;
  logic signed [UW-1:0]  u_q;
  logic                  err_q;

  logic signed [ACCW-1:0] acc_mem [NCH];
  logic signed [W-1:0]    y1_mem  [NCH];
  logic signed [W-1:0]    y2_mem  [NCH];

  logic                   ch_ok, can_take, accept, reject, skip_hit;
  logic signed [W-1:0]    y1_cur, y2_cur;
  logic signed [EW-1:0]   r_x, y_x, y1_x, y2_x;
  logic signed [W-1:0]    mac_gain;
  logic signed [EW-1:0]   mac_opnd;
  logic                   mac_sub;
  logic signed [ACCW-1:0] mac_res;
  logic signed [SatMaxW-1:0] acc_wide;
  logic signed [ACCW-1:0] acc_sat;
  logic signed [UW-1:0]   u_now;

  // SAT is also an accepting state so a new request can ride on the done cycle.
  assign ch_ok    = (32'(ch) < NCH);
  assign can_take = (state_q == StIdle) || (state_q == StSat);
  assign accept   = start && can_take && ch_ok;
  assign reject   = start && can_take && !ch_ok;

  assign y1_cur   = y1_mem[ch_q];
  assign y2_cur   = y2_mem[ch_q];
  assign r_x      = EW'(r_q);
  assign y_x      = EW'(y_q);
  assign y1_x     = EW'(y1_cur);
  assign y2_x     = EW'(y2_cur);
  assign skip_hit = skip_en_q && (y_q == y1_cur);

  always_comb begin
    mac_gain = ki_q;
    mac_opnd = e_q;
    mac_sub  = 1'b0;
    case (state_q)
      StMulP: begin
        mac_gain = kp_q;
        mac_opnd = dy_q;
        mac_sub  = 1'b1;
      end
      StMulD: begin
        mac_gain = kd_q;
        mac_opnd = d2y_q;
        mac_sub  = 1'b1;
      end
      default: ;
    endcase
  end

  ipd_mac #(
    .W    (W),
    .ACCW (ACCW)
  ) u_mac (
    .acc  (acc_q),
    .gain (mac_gain),
    .opnd (mac_opnd),
    .sub  (mac_sub),
    .res  (mac_res)
  );

  // The accumulator is Q(W-FRAC).FRAC, the same format as u, so clamping to W bits
  // makes the integer part saturate at the limits of u_out and bounds the stored
  // state (anti-windup).
  assign acc_wide = sat_signed(SatMaxW'(acc_q), W);
  assign acc_sat  = ACCW'(acc_wide);
  assign u_now    = acc_sat[FRAC +: UW];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StSat: state_d = accept ? StLoad : StIdle;
      StLoad:        state_d = skip_hit ? StSat : StMulI;
      StMulI:        state_d = StMulP;
      StMulP:        state_d = StMulD;
      StMulD:        state_d = StSat;
      default:       state_d = StIdle;
    endcase
  end

  assign busy   = (state_q == StLoad) || (state_q == StMulI) ||
                  (state_q == StMulP) || (state_q == StMulD);
  assign done   = (state_q == StSat);
  assign u_out  = done ? u_now : u_q;
  assign ch_out = done ? ch_q : ch_out_q;
  assign err    = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      r_q       <= '0;
      y_q       <= '0;
      ki_q      <= '0;
      kp_q      <= '0;
      kd_q      <= '0;
      skip_en_q <= 1'b0;
      skip_q    <= 1'b0;
      e_q       <= '0;
      dy_q      <= '0;
      d2y_q     <= '0;
      acc_q     <= '0;
      u_q       <= '0;
      ch_out_q  <= '0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        acc_mem[i] <= '0;
        y1_mem[i]  <= '0;
        y2_mem[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      err_q   <= reject;
      if (accept) begin
        ch_q      <= ch;
        r_q       <= r;
        y_q       <= y;
        ki_q      <= ki;
        kp_q      <= kp;
        kd_q      <= kd;
        skip_en_q <= skip_en;
      end
      case (state_q)
        StLoad: begin
          acc_q  <= acc_mem[ch_q];
          e_q    <= r_x - y_x;
          dy_q   <= y_x - y1_x;
          d2y_q  <= y_x - (y1_x <<< 1) + y2_x;
          skip_q <= skip_hit;
        end
        StMulI, StMulP, StMulD: acc_q <= mac_res;
        StSat: begin
          acc_mem[ch_q] <= acc_sat;
          if (!skip_q) begin
            y2_mem[ch_q] <= y1_cur;
            y1_mem[ch_q] <= y_q;
          end
          u_q      <= u_now;
          ch_out_q <= ch_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ipd_mc_seq.sv
// Self-checking bench for ipd_mc_seq: directed scenarios plus randomized requests,
// all checked against a per-channel arithmetic model of the control law.
module tb_ipd_mc_seq;

  localparam int unsigned W    = 20;
  localparam int unsigned FRAC = 12;
  localparam int unsigned NCH  = 5;
  localparam int unsigned CHW  = 3;
  localparam int unsigned UW   = W - FRAC;
  localparam longint      ONE  = 4096;  // 1.0 in gain format

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic [CHW-1:0]       ch = '0;
  logic                 skip_en = 1'b0;
  logic signed [W-1:0]  r = '0, y = '0, ki = '0, kp = '0, kd = '0;
  logic                 busy, done, err;
  logic [CHW-1:0]       ch_out;
  logic signed [UW-1:0] u_out;

  always #5 clk = ~clk;

  ipd_mc_seq #(
    .W    (W),
    .FRAC (FRAC),
    .NCH  (NCH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ch      (ch),
    .skip_en (skip_en),
    .r       (r),
    .y       (y),
    .ki      (ki),
    .kp      (kp),
    .kd      (kd),
    .busy    (busy),
    .done    (done),
    .ch_out  (ch_out),
    .u_out   (u_out),
    .err     (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per channel: stored (clamped) accumulator and the two previous y.
  longint acc_m [NCH];
  longint y1_m  [NCH];
  longint y2_m  [NCH];

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    longint hi = (longint'(1) <<< (W - 1)) - 1;
    longint lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic longint rnd_full();
    logic signed [W-1:0] t;
    t = W'($urandom);
    return longint'(t);
  endfunction

  function automatic longint rnd_small(input int span);
    return longint'($urandom_range(0, 2 * span)) - longint'(span);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      acc_m[i] = 0;
      y1_m[i]  = 0;
      y2_m[i]  = 0;
    end
  endtask

  // Issue one valid request at a negedge; returns at the negedge where done is seen.
  task automatic do_req(input int c, input longint rr, input longint yy, input longint gi,
                        input longint gp, input longint gd, input bit sk, input bit poke,
                        output longint got_u);
    longint exp_u;
    int     lat;
    bit     hit, seen;
    hit = sk && (yy == y1_m[c]);
    if (!hit) begin
      acc_m[c] = sat(acc_m[c] + gi * (rr - yy) - gp * (yy - y1_m[c])
                     - gd * (yy - 2 * y1_m[c] + y2_m[c]));
      y2_m[c] = y1_m[c];
      y1_m[c] = yy;
    end
    exp_u = acc_m[c] >>> FRAC;

    start = 1'b1; ch = CHW'(c); skip_en = sk;
    r = rr[W-1:0]; y = yy[W-1:0]; ki = gi[W-1:0]; kp = gp[W-1:0]; kd = gd[W-1:0];
    @(posedge clk);
    #1 start = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("busy_after_accept", longint'(busy), 1);
      if (poke && !hit && lat == 2) begin
        start = 1'b1;
        ch    = CHW'($urandom_range(0, NCH - 1));
        r     = W'($urandom);
        y     = W'($urandom);
      end
      if (poke && !hit && lat == 3) begin
        check("no_err_start_while_busy", longint'(err), 0);
        start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    check("latency", longint'(lat), hit ? 2 : 5);
    got_u = longint'($signed(u_out));
    check("u_out", got_u, exp_u);
    check("ch_out", longint'(ch_out), longint'(c));
    check("busy_at_done", longint'(busy), 0);
  endtask

  task automatic do_bad(input int c);
    start = 1'b1; ch = CHW'(c);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("err_pulse", longint'(err), 1);
    check("err_no_done", longint'(done), 0);
    check("err_not_busy", longint'(busy), 0);
    @(negedge clk);
    check("err_one_cycle", longint'(err), 0);
    check("err_no_done_late", longint'(done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint u, u1, u2, rr, yy, gi, gp, gd;
    int     c;
    bit     sk;

    model_clear();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_err", longint'(err), 0);
    check("rst_u_out", longint'($signed(u_out)), 0);
    check("rst_ch_out", longint'(ch_out), 0);
    rst = 1'b1;
    @(negedge clk);

    // Pure integral on ch0: steps of 30 per sample, back-to-back requests.
    do_req(0, 30, 0, ONE, 0, 0, 1'b0, 1'b0, u);
    check("int_step1", u, 30);
    do_req(0, 30, 0, ONE, 0, 0, 1'b0, 1'b1, u);
    check("int_step2", u, 60);
    do_req(0, 30, 0, ONE, 0, 0, 1'b0, 1'b0, u);
    check("int_step3", u, 90);

    // Reset during MUL_P aborts and clears every history.
    start = 1'b1; ch = '0; r = 20'sd500; y = '0; ki = 20'sd4096;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", longint'(busy), 0);
    check("midrst_done", longint'(done), 0);
    check("midrst_u_out", longint'($signed(u_out)), 0);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    do_req(0, 30, 0, ONE, 0, 0, 1'b0, 1'b0, u);
    check("first_after_rst", u, 30);

    // Proportional on measurement, then P+D.
    do_req(1, 0, 0, 0, ONE, 0, 1'b0, 1'b0, u);
    check("p_zero", u, 0);
    do_req(1, 0, 50, 0, ONE, 0, 1'b0, 1'b1, u);
    check("p_step", u, -50);
    do_req(2, 0, 0, 0, ONE, ONE, 1'b0, 1'b0, u);
    do_req(2, 0, 50, 0, ONE, ONE, 1'b0, 1'b0, u);
    check("pd_step", u, -100);

    // Saturation and immediate recovery (no windup).
    for (int i = 0; i < 3; i++) begin
      do_req(3, 524287, -524288, 524287, 0, 0, 1'b0, 1'b0, u);
      check("sat_hi", u, 127);
    end
    do_req(3, -524288, 0, 524287, 0, 0, 1'b0, 1'b0, u);
    check("sat_recover", u, -128);

    // Channel interleave and out-of-range channels.
    for (int i = 0; i < 4; i++) begin
      do_req(0, 20, 0, ONE, 0, 0, 1'b0, 1'b1, u);
      do_req(3, 40, 0, ONE, 0, 0, 1'b0, 1'b0, u);
    end
    do_bad(6);
    do_bad(5);
    do_req(0, 0, 0, ONE, 0, 0, 1'b0, 1'b0, u);

    // Skip mode: identical y leaves the output untouched and finishes early.
    do_req(4, 100, 7, ONE, ONE, 0, 1'b1, 1'b0, u1);
    do_req(4, 100, 7, ONE, ONE, 0, 1'b1, 1'b1, u2);
    check("skip_hold", u2, u1);
    @(negedge clk);
    check("u_out_held", longint'($signed(u_out)), acc_m[4] >>> FRAC);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      c = int'($urandom_range(0, 7));
      if (c >= int'(NCH)) begin
        do_bad(c);
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          rr = rnd_full(); gi = rnd_full(); gp = rnd_full(); gd = rnd_full();
        end else begin
          rr = rnd_small(3000); gi = rnd_small(8192); gp = rnd_small(8192);
          gd = rnd_small(4096);
        end
        yy = ($urandom_range(0, 3) == 0) ? y1_m[c] : rnd_small(3000);
        sk = 1'($urandom_range(0, 1));
        do_req(c, rr, yy, gi, gp, gd, sk, 1'($urandom_range(0, 1)), u);
        if ($urandom_range(0, 2) == 0) @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
